// File: rtl/urv_tb_host_pkg.sv
// Shared constants and types for the uRV testbench host interface.
package urv_tb_host_pkg;

    localparam int unsigned c_REG_OFF_W = 2;

    localparam logic [c_REG_OFF_W-1:0] c_REG_TXDATA = 2'd0;
    localparam logic [c_REG_OFF_W-1:0] c_REG_TEST   = 2'd1;
    localparam logic [c_REG_OFF_W-1:0] c_REG_CYCLE  = 2'd2;
    localparam logic [c_REG_OFF_W-1:0] c_REG_STATUS = 2'd3;

    localparam int unsigned c_STATUS_FULL      = 0;
    localparam int unsigned c_STATUS_EMPTY     = 1;
    localparam int unsigned c_STATUS_LEVEL_LSB = 8;
    localparam int unsigned c_STATUS_LEVEL_W   = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TX_WAIT = 2'd1,
        ACK_LD  = 2'd2,
        ACK_ST  = 2'd3
    } t_host_state;

    // Assemble the STATUS word from FIFO flags and the (truncated) fill level.
    function automatic logic [31:0] pack_status(input logic full, input logic empty,
                                                input logic [c_STATUS_LEVEL_W-1:0] level);
        logic [31:0] s;
        s = '0;
        s[c_STATUS_FULL]  = full;
        s[c_STATUS_EMPTY] = empty;
        s[c_STATUS_LEVEL_LSB +: c_STATUS_LEVEL_W] = level;
        return s;
    endfunction

endpackage

// File: rtl/urv_tb_host_fifo.sv
// Console TX byte FIFO: synchronous, no empty bypass, flags from start-of-cycle state.
module urv_tb_host_fifo #(
    parameter int unsigned g_depth = 16,
    localparam int unsigned c_LW   = $clog2(g_depth) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic [7:0]      data_i,
    input  logic            pop_i,
    output logic [7:0]      data_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [c_LW-1:0] level_o
);

    localparam int unsigned c_AW = $clog2(g_depth);

    logic [7:0]      mem [g_depth];
    logic [c_AW-1:0] wr_ptr;
    logic [c_AW-1:0] rd_ptr;
    logic [c_LW-1:0] level_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (level_q == c_LW'(g_depth));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

    // A push against a full FIFO is refused even if a pop happens in the same cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Head byte is forced to zero while empty so the output is defined out of reset.
    assign data_o = empty_o ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + c_AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + c_AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + c_LW'(1);
                2'b01:   level_q <= level_q - c_LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/urv_tb_host_if.sv
// Memory-mapped host window on the uRV data bus: console TX FIFO, test-done flag,
// cycle counter and status word, with store stall while the TX FIFO is full.
module urv_tb_host_if
    import urv_tb_host_pkg::*;
#(
    parameter logic [31:0] g_base_addr  = 32'h0010_0000,
    parameter int unsigned g_fifo_depth = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_store_i,
    input  logic        dm_load_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_store_done_o,
    output logic        dm_load_done_o,
    output logic        hit_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        test_done_o,
    output logic [31:0] test_code_o
);

    localparam int unsigned c_LW = $clog2(g_fifo_depth) + 1;

    t_host_state             state;
    logic [31:0]             cycle_q;
    logic [c_REG_OFF_W-1:0]  reg_off;
    logic                    push_c;
    logic                    pop_c;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [c_LW-1:0]         fifo_level;
    logic [31:0]             status_c;
    logic [31:0]             rdata_c;
    logic                    unused_c;

    assign hit_o    = (dm_addr_i[31:4] == g_base_addr[31:4]);
    assign reg_off  = dm_addr_i[3:2];
    assign unused_c = ^{dm_addr_i[1:0], dm_data_select_i[3:1]};

    assign tx_valid_o = ~fifo_empty;
    assign pop_c      = tx_valid_o & tx_ready_i;

    urv_tb_host_fifo #(
        .g_depth (g_fifo_depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_c),
        .data_i  (dm_data_s_i[7:0]),
        .pop_i   (pop_c),
        .data_o  (tx_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Push request: an unstalled TXDATA store in IDLE, or the first free slot while waiting.
    always_comb begin
        push_c = 1'b0;
        if (state == IDLE) begin
            push_c = hit_o & dm_store_i & (reg_off == c_REG_TXDATA)
                   & ~fifo_full & dm_data_select_i[0];
        end else if (state == TX_WAIT) begin
            push_c = ~fifo_full & dm_data_select_i[0];
        end
    end

    // Read data mux; TXDATA reads alias STATUS.
    always_comb begin
        status_c = pack_status(fifo_full, fifo_empty, c_STATUS_LEVEL_W'(fifo_level));
        rdata_c  = status_c;
        case (reg_off)
            c_REG_TEST:  rdata_c = {31'b0, test_done_o};
            c_REG_CYCLE: rdata_c = cycle_q;
            default:     rdata_c = status_c;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    // Bus FSM; done outputs are registered and coincide with the ACK states.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            dm_data_l_o     <= '0;
            dm_store_done_o <= 1'b0;
            dm_load_done_o  <= 1'b0;
            test_done_o     <= 1'b0;
            test_code_o     <= '0;
        end else begin
            dm_store_done_o <= 1'b0;
            dm_load_done_o  <= 1'b0;
            dm_data_l_o     <= '0;
            case (state)
                IDLE: begin
                    if (hit_o && dm_store_i) begin
                        if (reg_off == c_REG_TXDATA && fifo_full) begin
                            state <= TX_WAIT;
                        end else begin
                            state           <= ACK_ST;
                            dm_store_done_o <= 1'b1;
                            if (reg_off == c_REG_TEST && !test_done_o) begin
                                test_done_o <= 1'b1;
                                test_code_o <= dm_data_s_i;
                            end
                        end
                    end else if (hit_o && dm_load_i) begin
                        state          <= ACK_LD;
                        dm_load_done_o <= 1'b1;
                        dm_data_l_o    <= rdata_c;
                    end
                end
                TX_WAIT: begin
                    if (!fifo_full) begin
                        state           <= ACK_ST;
                        dm_store_done_o <= 1'b1;
                    end
                end
                ACK_LD:  state <= IDLE;
                ACK_ST:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_urv_tb_host_if.sv
// Directed bench for urv_tb_host_if: register table plus hand-written stall/reset sequences.
module tb_urv_tb_host_if;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        store;
    logic        load;
    logic [31:0] rdata;
    logic        store_done;
    logic        load_done;
    logic        hit;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        test_done;
    logic [31:0] test_code;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] popped [$];

    always #5 clk = ~clk;

    urv_tb_host_if dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .dm_addr_i        (addr),
        .dm_data_s_i      (wdata),
        .dm_data_select_i (sel),
        .dm_store_i       (store),
        .dm_load_i        (load),
        .dm_data_l_o      (rdata),
        .dm_store_done_o  (store_done),
        .dm_load_done_o   (load_done),
        .hit_o            (hit),
        .tx_data_o        (tx_data),
        .tx_valid_o       (tx_valid),
        .tx_ready_i       (tx_ready),
        .test_done_o      (test_done),
        .test_code_o      (test_code)
    );

    always @(posedge clk) begin
        if (!rst && tx_valid && tx_ready) popped.push_back(tx_data);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One idle cycle, then a load; lat = edges until load_done (-1 on timeout).
    task automatic do_load(input logic [31:0] a, output logic [31:0] d, output int lat);
        @(posedge clk); #1;
        addr = a; load = 1'b1; lat = -1; d = 'x;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (load_done) begin lat = i; d = rdata; break; end
        end
        load = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output int lat);
        @(posedge clk); #1;
        addr = a; wdata = d; sel = s; store = 1'b1; lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (store_done) begin lat = i; break; end
        end
        store = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        bit          st;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t        vecs [8];
        logic [31:0] d, v1, v2;
        int          lat, cnt;

        rst = 1'b1; addr = '0; wdata = '0; sel = '0; store = 1'b0; load = 1'b0; tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_l", rdata, 32'h0);
        check("rst_st_done", 32'(store_done), 32'h0);
        check("rst_ld_done", 32'(load_done), 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_test_done", 32'(test_done), 32'h0);
        check("rst_test_code", test_code, 32'h0);

        // CYCLE reads 0 when loaded in the first cycle out of reset.
        rst = 1'b0; addr = 32'h0010_0008; load = 1'b1;
        @(posedge clk); #1;
        check("cycle0_done", 32'(load_done), 32'h1);
        check("cycle0_val", rdata, 32'h0);
        load = 1'b0;

        vecs[0] = '{32'h0010_0000, 32'h0,      4'h0, 1'b0, 32'h0000_0002};
        vecs[1] = '{32'h0010_000C, 32'h0,      4'h0, 1'b0, 32'h0000_0002};
        vecs[2] = '{32'h0010_0004, 32'h0,      4'h0, 1'b0, 32'h0000_0000};
        vecs[3] = '{32'h0010_0008, 32'h1234,   4'hF, 1'b1, 32'h0};
        vecs[4] = '{32'h0010_000C, 32'hFFFF,   4'hF, 1'b1, 32'h0};
        vecs[5] = '{32'h0010_0000, 32'h55,     4'hE, 1'b1, 32'h0};
        vecs[6] = '{32'h0010_000C, 32'h0,      4'h0, 1'b0, 32'h0000_0002};
        vecs[7] = '{32'h0010_0004, 32'h0,      4'h0, 1'b0, 32'h0000_0000};
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].st) begin
                do_store(vecs[i].a, vecs[i].d, vecs[i].s, lat);
            end else begin
                do_load(vecs[i].a, d, lat);
                check($sformatf("vec%0d_data", i), d, vecs[i].exp);
            end
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd1);
            check($sformatf("vec%0d_txv", i), 32'(tx_valid), 32'h0);
        end

        // Two CYCLE reads: sample edges are 11 cycles apart here.
        do_load(32'h0010_0008, v1, lat);
        repeat (9) @(posedge clk);
        do_load(32'h0010_0008, v2, lat);
        check("cycle_delta_ok", 32'((v2 - v1) >= 32'd9 && (v2 - v1) <= 32'd11), 32'h1);

        // Streaming with the consumer ready.
        popped.delete();
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_store(32'h0010_0000, 32'h41 + 32'(i), 4'h1, lat);
            check($sformatf("tx_lat%0d", i), 32'(lat), 32'd1);
        end
        repeat (4) @(posedge clk);
        #1;
        check("tx_count", 32'(popped.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("tx_byte%0d", i),
                  (i < popped.size()) ? 32'(popped[i]) : 32'hxxxx_xxxx, 32'h41 + 32'(i));
        end

        // Fill the FIFO with the consumer stalled, then stall the 17th store.
        tx_ready = 1'b0;
        popped.delete();
        for (int i = 0; i < 16; i++) begin
            do_store(32'h0010_0000, 32'h60 + 32'(i), 4'h1, lat);
            check($sformatf("fill_lat%0d", i), 32'(lat), 32'd1);
        end
        do_load(32'h0010_000C, d, lat);
        check("full_status", d, 32'h0000_1001);
        check("head_byte", 32'(tx_data), 32'h60);
        @(posedge clk); #1;
        addr = 32'h0010_0000; wdata = 32'h70; sel = 4'h1; store = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("stall_nodone%0d", i), 32'(store_done), 32'h0);
        end
        tx_ready = 1'b1;
        cnt = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (store_done) begin cnt = i; break; end
        end
        store = 1'b0;
        check("stall_release_lat", 32'(cnt), 32'd2);
        repeat (25) @(posedge clk);
        #1;
        check("drain_count", 32'(popped.size()), 32'd17);
        for (int i = 0; i < 17; i++) begin
            check($sformatf("drain_byte%0d", i),
                  (i < popped.size()) ? 32'(popped[i]) : 32'hxxxx_xxxx, 32'h60 + 32'(i));
        end

        // Sticky test flag: first write wins.
        do_store(32'h0010_0004, 32'h0, 4'hF, lat);
        check("test1_lat", 32'(lat), 32'd1);
        check("test1_done", 32'(test_done), 32'h1);
        check("test1_code", test_code, 32'h0);
        do_store(32'h0010_0004, 32'hDEAD, 4'hF, lat);
        check("test2_done", 32'(test_done), 32'h1);
        check("test2_code", test_code, 32'h0);
        do_load(32'h0010_0004, d, lat);
        check("test_read", d, 32'h1);

        // Out-of-window access is not acknowledged.
        @(posedge clk); #1;
        addr = 32'h0020_0000; load = 1'b1;
        #1;
        check("miss_hit", 32'(hit), 32'h0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (load_done) cnt++;
        end
        load = 1'b0;
        check("miss_nodone", 32'(cnt), 32'h0);
        addr = 32'h0010_000C;
        #1;
        check("win_hit", 32'(hit), 32'h1);

        // Write to CYCLE is acknowledged and ignored.
        do_load(32'h0010_0008, v1, lat);
        do_store(32'h0010_0008, 32'h0, 4'hF, lat);
        check("cyc_wr_lat", 32'(lat), 32'd1);
        do_load(32'h0010_0008, v2, lat);
        check("cyc_wr_delta", v2 - v1, 32'd4);

        // Reset while a store is stalled in TX_WAIT.
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            do_store(32'h0010_0000, 32'h80 + 32'(i), 4'h1, lat);
        end
        @(posedge clk); #1;
        addr = 32'h0010_0000; wdata = 32'h99; sel = 4'h1; store = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst2_txvalid", 32'(tx_valid), 32'h0);
        check("rst2_st_done", 32'(store_done), 32'h0);
        check("rst2_test_done", 32'(test_done), 32'h0);
        rst = 1'b0; store = 1'b0; addr = 32'h0010_0008; load = 1'b1;
        @(posedge clk); #1;
        check("rst2_ld_done", 32'(load_done), 32'h1);
        check("rst2_cycle", rdata, 32'h0);
        check("rst2_st_done2", 32'(store_done), 32'h0);
        load = 1'b0;
        do_load(32'h0010_000C, d, lat);
        check("rst2_status", d, 32'h0000_0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
